mandel_pixel_scheduler: RTL and testbench

Shares the single pixel-write port of video_controller between NUM_REQ Mandelbrot iteration engines using round-robin arbitration. Each engine offers one pixel at a time (x, y, colour) over a valid/ready handshake. The block also provides a full-screen clear sweep, used on zoom/pan before a new frame is computed. Its registered outputs drive video_controller's plot/x/y/colour directly.

---
 rtl/mandel_pixel_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_mandel_pixel_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_pixel_scheduler.sv
// Round-robin scheduler sharing one pixel-write port among NUM_REQ engines, plus full-screen clear sweep.
// Optional macro PIXEL_STATS_EN adds plot_count/drop_count statistics outputs.
`timescale 1ns/1ps

module mandel_pixel_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned H_RES        = 320,
  parameter int unsigned V_RES        = 240,
  parameter logic [11:0] CLEAR_COLOUR = 12'h000
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [9*NUM_REQ-1:0]  req_x,
  input  logic [9*NUM_REQ-1:0]  req_y,
  input  logic [12*NUM_REQ-1:0] req_colour,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  plot,
  output logic [8:0]            x,
  output logic [8:0]            y,
  output logic [11:0]           colour
`ifdef PIXEL_STATS_EN
  ,
  output logic [31:0]           plot_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int unsigned XY_W  = 9;
  localparam int unsigned COL_W = 12;
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [XY_W-1:0] H_MAX = XY_W'(H_RES - 1);
  localparam logic [XY_W-1:0] V_MAX = XY_W'(V_RES - 1);
  localparam logic [XY_W:0]   H_LIM = (XY_W + 1)'(H_RES);
  localparam logic [XY_W:0]   V_LIM = (XY_W + 1)'(V_RES);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [PTR_W-1:0]  w_grant;
  logic              w_any;
  logic              w_xfer;
  logic              w_sweep_emit;
  logic              w_clear_go;
  logic [XY_W-1:0]   r_sx;
  logic [XY_W-1:0]   r_sy;
  logic              r_sweep_last;
  logic [XY_W-1:0]   w_x;
  logic [XY_W-1:0]   w_y;
  logic [COL_W-1:0]  w_col;
  logic              w_in_range;

  function automatic logic [PTR_W-1:0] f_wrap(input int unsigned v);
    f_wrap = PTR_W'(v % NUM_REQ);
  endfunction

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_any && req_valid[f_wrap(32'(r_rr_ptr) + k)]) begin
        w_any   = 1'b1;
        w_grant = f_wrap(32'(r_rr_ptr) + k);
      end
    end
  end

  always_comb begin
    w_x   = '0;
    w_y   = '0;
    w_col = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == PTR_W'(i)) begin
        w_x   = req_x[XY_W*i +: XY_W];
        w_y   = req_y[XY_W*i +: XY_W];
        w_col = req_colour[COL_W*i +: COL_W];
      end
    end
  end

  assign w_in_range = ({1'b0, w_x} < H_LIM) && ({1'b0, w_y} < V_LIM);

  // Next state and handshake; a clear request masks any grant in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = '0;
    w_xfer       = 1'b0;
    w_sweep_emit = 1'b0;
    w_clear_go   = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (clear_start) begin
          w_state_nxt = ST_CLEAR;
          w_clear_go  = 1'b1;
        end else if (w_any) begin
          req_ready[w_grant] = 1'b1;
          w_xfer             = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (r_sweep_last) begin
          w_state_nxt = ST_ARB;
        end else begin
          w_sweep_emit = 1'b1;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Raster counters; r_sweep_last marks that the final pixel has been issued.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sx         <= '0;
      r_sy         <= '0;
      r_sweep_last <= 1'b0;
    end else if (w_clear_go) begin
      r_sx         <= '0;
      r_sy         <= '0;
      r_sweep_last <= 1'b0;
    end else if (w_sweep_emit) begin
      if (r_sx == H_MAX) begin
        r_sx <= '0;
        if (r_sy == V_MAX) begin
          r_sy         <= '0;
          r_sweep_last <= 1'b1;
        end else begin
          r_sy <= r_sy + XY_W'(1);
        end
      end else begin
        r_sx <= r_sx + XY_W'(1);
      end
    end else if (r_state == ST_CLEAR) begin
      r_sweep_last <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= f_wrap(32'(w_grant) + 32'd1);
    end
  end

  // Registered pixel port and sweep status.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_busy <= (w_state_nxt == ST_CLEAR);
      clear_done <= (r_state == ST_CLEAR) && (w_state_nxt == ST_ARB);
      if (w_xfer) begin
        plot   <= w_in_range;
        x      <= w_x;
        y      <= w_y;
        colour <= w_col;
      end else if (w_sweep_emit) begin
        plot   <= 1'b1;
        x      <= r_sx;
        y      <= r_sy;
        colour <= CLEAR_COLOUR;
      end else begin
        plot <= 1'b0;
      end
    end
  end

`ifdef PIXEL_STATS_EN
  // Arbitrated plot and out-of-range drop statistics; sweep pixels are not counted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      plot_count <= '0;
      drop_count <= '0;
    end else if (w_clear_go) begin
      plot_count <= '0;
      drop_count <= '0;
    end else if (w_xfer) begin
      if (w_in_range) begin
        plot_count <= plot_count + 32'd1;
      end else if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Scoreboard bench for mandel_pixel_scheduler: reference model pushes expected pixels, monitor pops on plot.
`timescale 1ns/1ps

module tb_mandel_pixel_scheduler;

  localparam int N    = 4;
  localparam int H    = 40;
  localparam int V    = 30;
  localparam int HV   = H * V;
  localparam int KRST = 5 * H + 10;
  localparam logic [11:0] CC = 12'h3C5;

  logic            clock;
  logic            resetn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [9*N-1:0]  req_x;
  logic [9*N-1:0]  req_y;
  logic [12*N-1:0] req_colour;
  logic            clear_start;
  logic            clear_busy;
  logic            clear_done;
  logic            plot;
  logic [8:0]      x;
  logic [8:0]      y;
  logic [11:0]     colour;

  mandel_pixel_scheduler #(
    .NUM_REQ(N), .H_RES(H), .V_RES(V), .CLEAR_COLOUR(CC)
  ) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .plot(plot), .x(x), .y(y), .colour(colour)
  );

  typedef struct {
    int px;
    int py;
    int pc;
    int pcyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   rr       = 0;
  bit   in_clear = 0;
  int   clear_c  = 0;
  bit   v[N];
  int   dx[N];
  int   dy[N];
  int   dc[N];
  bit   start;
  int   g;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic push_px(input int px, input int py, input int pc, input int pcyc);
    exp_t e;
    e.px = px; e.py = py; e.pc = pc; e.pcyc = pcyc;
    q.push_back(e);
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = v[i];
      req_x[9*i +: 9]        = 9'(dx[i]);
      req_y[9*i +: 9]        = 9'(dy[i]);
      req_colour[12*i +: 12] = 12'(dc[i]);
    end
    clear_start = start;
  endtask

  // Reference model evaluated once per cycle against the inputs currently applied.
  task automatic model_eval(output int gnt);
    bit           in_clr;
    logic [N-1:0] exp_rdy;
    gnt     = -1;
    exp_rdy = '0;
    in_clr  = in_clear && (cyc > clear_c) && (cyc < clear_c + HV + 2);
    chk("clear_busy", 64'(clear_busy), 64'(in_clr));
    chk("clear_done", 64'(clear_done), 64'(in_clear && (cyc == clear_c + HV + 2)));
    if (in_clear && (cyc >= clear_c + HV + 2)) in_clear = 0;
    if (!in_clr) begin
      if (start) begin
        in_clear = 1;
        clear_c  = cyc;
        for (int k = 0; k < HV; k++) push_px(k % H, k / H, int'(CC), cyc + 2 + k);
      end else begin
        for (int k = 0; k < N; k++)
          if (gnt < 0 && v[(rr + k) % N]) gnt = (rr + k) % N;
        if (gnt >= 0) begin
          exp_rdy[gnt] = 1'b1;
          rr = (gnt + 1) % N;
          if (dx[gnt] < H && dy[gnt] < V) push_px(dx[gnt], dy[gnt], dc[gnt], cyc + 1);
        end
      end
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
  endtask

  task automatic cycle(output int gnt);
    @(posedge clock);
    #1;
    apply_inputs();
    @(negedge clock);
    model_eval(gnt);
  endtask

  task automatic rand_refresh(input int lg);
    for (int i = 0; i < N; i++) begin
      if (!v[i] || lg == i) begin
        v[i]  = ($urandom_range(0, 3) != 0);
        dx[i] = ($urandom_range(0, 15) == 0) ? 511 : int'($urandom_range(0, H + 2));
        dy[i] = ($urandom_range(0, 15) == 0) ? 511 : int'($urandom_range(0, V + 2));
        dc[i] = int'($urandom_range(0, 4095));
      end
    end
  endtask

  task automatic reset_dut();
    #2;
    for (int i = 0; i < N; i++) v[i] = 0;
    start = 0;
    apply_inputs();
    resetn = 1'b0;
    #1;
    chk("rst_outputs", 64'({plot, x, y, colour, clear_busy, clear_done}), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    q.delete();
    rr       = 0;
    in_clear = 0;
    repeat (2) @(negedge clock);
    #2;
    resetn = 1'b1;
  endtask

  // Monitor: each plot strobe must match the oldest expected pixel, on its expected cycle.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (resetn === 1'b1) begin
      if (plot === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_plot", 64'(plot), 64'd0);
        end else begin
          e = q.pop_front();
          chk("pixel", 64'({16'(cyc), x, y, colour}),
              64'({16'(e.pcyc), 9'(e.px), 9'(e.py), 12'(e.pc)}));
        end
      end else if (q.size() != 0 && q[0].pcyc <= cyc) begin
        chk("missing_plot", 64'(plot), 64'd1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < N; i++) begin
      v[i] = 0; dx[i] = 0; dy[i] = 0; dc[i] = 0;
    end
    start = 0;
    apply_inputs();
    reset_dut();

    // Lone engine 2 from reset.
    v[2] = 1; dx[2] = 10; dy[2] = 20; dc[2] = 12'hABC;
    cycle(g);
    v[2] = 0;
    repeat (2) cycle(g);

    // All engines valid from pointer 0: grants rotate 0,1,2,3,...
    reset_dut();
    for (int i = 0; i < N; i++) begin
      v[i] = 1; dx[i] = 3 * i + 1; dy[i] = i + 2; dc[i] = 12'h100 + i;
    end
    repeat (8) cycle(g);
    for (int i = 0; i < N; i++) v[i] = 0;
    repeat (2) cycle(g);

    // Out-of-range pixels complete the handshake but never plot; then the in-range corner.
    v[0] = 1; dx[0] = H;     dy[0] = 5;     dc[0] = 12'h111;
    cycle(g);
    dx[0] = 5;     dy[0] = V;
    cycle(g);
    dx[0] = H - 1; dy[0] = V - 1;
    cycle(g);
    v[0] = 0;
    repeat (2) cycle(g);

    // Random traffic with protocol-correct holding of pending requests.
    g = -1;
    repeat (300) begin
      rand_refresh(g);
      cycle(g);
    end
    for (int i = 0; i < N; i++) v[i] = 0;
    repeat (2) cycle(g);

    // Clear sweep requested alongside engine 1; a second clear_start mid-sweep is ignored.
    v[1] = 1; dx[1] = 7; dy[1] = 8; dc[1] = 12'h777;
    start = 1;
    cycle(g);
    for (int t = 0; t < HV + 12; t++) begin
      start = (t == 50);
      rand_refresh(g);
      cycle(g);
    end
    start = 0;
    for (int i = 0; i < N; i++) v[i] = 0;
    repeat (3) cycle(g);

    // Reset in the middle of a sweep, at pixel (10,5).
    start = 1;
    cycle(g);
    start = 0;
    repeat (KRST + 2) cycle(g);
    chk("sweep_point", 64'({x, y}), 64'({9'd10, 9'd5}));
    reset_dut();
    for (int i = 0; i < N; i++) begin
      v[i] = 1; dx[i] = i; dy[i] = 2 * i; dc[i] = 12'h0F0 + i;
    end
    repeat (4) cycle(g);
    for (int i = 0; i < N; i++) v[i] = 0;
    repeat (4) cycle(g);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
